// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - PS/2 scan-code to one-hot direction decoder (optional macro: PS2_WASD_EN)
module ps2_dir_decoder #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [7:0] scan_code,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       any_held,
  output logic       dir_changed
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  // Key bits throughout: [0]=up [1]=down [2]=left [3]=right.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       held_q, held_d;
  logic [3:0]       last_q, last_d;   // one-hot, zero means no key
  logic [3:0]       dir_q, dir_d;
  logic             dc_q, dc_d;

  logic             do_make;
  logic             do_break;
  logic             key_ext;
  logic [3:0]       key;

  // Map a (prefix, code) pair to a one-hot key; zero for unmapped codes.
  function automatic logic [3:0] key_map(input logic ext, input logic [7:0] code);
    logic [3:0] k;
    k = 4'b0000;
    if (ext) begin
      case (code)
        8'h75:   k = 4'b0001;
        8'h72:   k = 4'b0010;
        8'h6B:   k = 4'b0100;
        8'h74:   k = 4'b1000;
        default: k = 4'b0000;
      endcase
    end else begin
`ifdef PS2_WASD_EN
      case (code)
        8'h1D:   k = 4'b0001;
        8'h1B:   k = 4'b0010;
        8'h1C:   k = 4'b0100;
        8'h23:   k = 4'b1000;
        default: k = 4'b0000;
      endcase
`else
      k = 4'b0000;
`endif
    end
    return k;
  endfunction

  // Next-state: prefix FSM, prefix timeout, held mask and most-recent-key tracking.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    last_d   = last_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    key_ext  = 1'b0;

    if (valid) begin
      // A byte always restarts the prefix timer, even on the expiry cycle.
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hE0)      state_d = EXT;
          else if (scan_code == 8'hF0) state_d = BRK;
          else                         do_make = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hE0)      state_d = EXT;
          else if (scan_code == 8'hF0) state_d = EXT_BRK;
          else begin
            do_make = 1'b1;
            key_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          do_break = 1'b1;
          state_d  = IDLE;
        end
        EXT_BRK: begin
          do_break = 1'b1;
          key_ext  = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_MAX) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    key = key_map(key_ext, scan_code);

    // Typematic repeats of a held key leave the most-recent choice untouched.
    if (do_make && (key != 4'b0000) && ((held_q & key) == 4'b0000)) begin
      held_d = held_q | key;
      last_d = key;
    end

    // Releasing the most-recent key falls back to the highest-priority key still held.
    if (do_break && ((held_q & key) != 4'b0000)) begin
      held_d = held_q & ~key;
      if (last_q == key) last_d = held_d & (~held_d + 4'd1);
    end

    dir_d = last_d & held_d;
    dc_d  = (dir_d != dir_q);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 4'b0000;
      last_q  <= 4'b0000;
      dir_q   <= 4'b0000;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      dc_q    <= dc_d;
    end
  end

  assign up          = dir_q[0];
  assign down        = dir_q[1];
  assign left        = dir_q[2];
  assign right       = dir_q[3];
  assign any_held    = |held_q;
  assign dir_changed = dc_q;

endmodule
